// File: rtl/huffman_fixed_pack_if.sv
// Token-in / packed-word-out bundle for huffman_fixed_pack.
// master = producer+sink side (bench/LZ77), slave = the packer.
interface huffman_fixed_pack_if #(
  parameter int OUT_WD = 32
);
  localparam int BYT_WD = $clog2(OUT_WD/8) + 1;

  logic              val_i;
  logic              rdy_o;
  logic              flg_lit_i;
  logic [7:0]        lit_dat_i;
  logic [8:0]        len_dat_i;
  logic [15:0]       dis_dat_i;
  logic              eob_i;
  logic              fin_i;
  logic              val_o;
  logic              rdy_i;
  logic [OUT_WD-1:0] dat_o;
  logic [BYT_WD-1:0] byt_o;
  logic              lst_o;

  modport master (
    output val_i, flg_lit_i, lit_dat_i,
    output len_dat_i, dis_dat_i, eob_i,
    output fin_i, rdy_i,
    input  rdy_o, val_o, dat_o, byt_o, lst_o
  );

  modport slave (
    input  val_i, flg_lit_i, lit_dat_i,
    input  len_dat_i, dis_dat_i, eob_i,
    input  fin_i, rdy_i,
    output rdy_o, val_o, dat_o, byt_o, lst_o
  );
endinterface

// File: rtl/huffman_fixed_pack.sv
// Fixed-Huffman DEFLATE encoder + LSB-first bit packer.
// Ports: clk, rst (sync, high), bus (token in, OUT_WD-bit words out).
module huffman_fixed_pack #(
  parameter int OUT_WD = 32
) (
  input logic                clk,
  input logic                rst,
  huffman_fixed_pack_if.slave bus
);
  localparam int BYT_WD = $clog2(OUT_WD/8) + 1;
  localparam int ACC_WD = OUT_WD + 32;
  localparam int CNT_WD = $clog2(ACC_WD + 1);
  localparam logic [CNT_WD-1:0] OUT_C = CNT_WD'(OUT_WD);
  localparam logic [BYT_WD-1:0] FULL_B = BYT_WD'(OUT_WD/8);

  typedef enum logic [1:0] {IDLE, SYM, EOB, FLUSH} state_t;

  state_t            state, state_n;
  logic [ACC_WD-1:0] acc, acc_n, post_acc, add_bits;
  logic [CNT_WD-1:0] cnt, cnt_n, post_cnt, add_len;
  logic              fin_q, fin_n;
  logic              drain, space, rnd;
  logic              val_w, rdy_w, lst_w;
  logic [BYT_WD-1:0] byt_w;

  logic [8:0]  l_off, l_sym, l_ext, code;
  logic [3:0]  l_k, l_m, clen;
  logic [15:0] d_off, d_ext;
  logic [3:0]  d_k, d_m;
  logic [4:0]  d_code, d_rev;
  logic [5:0]  tlen, sh_dc, sh_dx;
  logic [30:0] tw, tok;
  logic [4:0]  tok_len;

  function automatic logic [3:0] msb16(
    input logic [15:0] v
  );
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) m = 4'(i);
    return m;
  endfunction

  // Huffman codes go out MSB first, so
  // they land bit-reversed in the LSB-first stream.
  function automatic logic [8:0] rev9(
    input logic [8:0] c,
    input logic [3:0] n
  );
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 9; i++)
      if (i < int'(n)) r[i] = c[int'(n) - 1 - i];
    return r;
  endfunction

  always_comb begin : tok_enc
    l_off = bus.len_dat_i - 9'd3;
    l_m   = msb16({7'd0, l_off});
    l_k   = '0;
    l_sym = 9'd257 + l_off;
    if (l_off == 9'd255) begin
      l_sym = 9'd285;
    end else if (l_off >= 9'd8) begin
      // group of 4 codes per extra-bit width k
      l_k   = l_m - 4'd2;
      l_sym = 9'd265 + {3'd0, l_k - 4'd1, 2'd0}
            + (l_off >> l_k) - 9'd4;
    end
    l_ext = l_off & ((9'd1 << l_k) - 9'd1);

    d_off  = bus.dis_dat_i - 16'd1;
    d_m    = msb16(d_off);
    d_k    = '0;
    d_code = d_off[4:0];
    if (d_off >= 16'd4) begin
      d_k    = d_m - 4'd1;
      d_code = {d_k, 1'b0} + {4'd0, d_off[d_k]}
             + 5'd2;
    end
    d_ext = d_off & ((16'd1 << d_k) - 16'd1);
    d_rev = {d_code[0], d_code[1], d_code[2],
             d_code[3], d_code[4]};

    code = '0;
    clen = '0;
    if (bus.flg_lit_i) begin
      if (bus.lit_dat_i < 8'd144) begin
        code = 9'h030 + {1'b0, bus.lit_dat_i};
        clen = 4'd8;
      end else begin
        code = 9'h190 + {1'b0, bus.lit_dat_i}
             - 9'd144;
        clen = 4'd9;
      end
    end else if (l_sym < 9'd280) begin
      code = l_sym - 9'd256;
      clen = 4'd7;
    end else begin
      code = l_sym - 9'd280 + 9'h0C0;
      clen = 4'd8;
    end

    sh_dc = {2'd0, clen} + {2'd0, l_k};
    sh_dx = sh_dc + 6'd5;
    tw    = 31'(rev9(code, clen));
    tlen  = {2'd0, clen};
    if (!bus.flg_lit_i) begin
      tw = tw
         | (31'(l_ext) << clen)
         | (31'(d_rev) << sh_dc)
         | (31'(d_ext) << sh_dx);
      tlen = sh_dx + {2'd0, d_k};
    end
    // garbage len/dis can exceed 31 bits
    if (tlen > 6'd31) tlen = 6'd31;
    tok     = tw & ((31'd1 << tlen) - 31'd1);
    tok_len = tlen[4:0];
  end

  always_comb begin : fsm
    val_w = (cnt >= OUT_C)
         || (state == FLUSH && cnt != '0);
    drain = val_w && bus.rdy_i;
    space = (cnt < OUT_C) || drain;

    post_acc = acc;
    post_cnt = cnt;
    if (drain) begin
      post_acc = acc >> OUT_WD;
      post_cnt = (cnt >= OUT_C) ? cnt - OUT_C : '0;
    end

    state_n  = state;
    fin_n    = fin_q;
    add_bits = '0;
    add_len  = '0;
    rnd      = 1'b0;
    rdy_w    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.val_i) begin
          // stream order: BFINAL, then BTYPE=01
          add_bits = ACC_WD'({2'b01, bus.fin_i});
          add_len  = CNT_WD'(3);
          fin_n    = bus.fin_i;
          state_n  = SYM;
        end
      end
      SYM: begin
        rdy_w = space;
        if (bus.val_i && space) begin
          add_bits = ACC_WD'(tok);
          add_len  = CNT_WD'(tok_len);
          if (bus.eob_i) state_n = EOB;
        end
      end
      EOB: begin
        if (space) begin
          add_len = CNT_WD'(7);
          rnd     = fin_q;
          state_n = fin_q ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (cnt == '0 || (drain && cnt <= OUT_C))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    acc_n = post_acc | (add_bits << post_cnt);
    cnt_n = post_cnt + add_len;
    // pad to a byte boundary; acc above cnt is 0
    if (rnd)
      cnt_n = (cnt_n + CNT_WD'(7)) & ~CNT_WD'(7);

    lst_w = (state == FLUSH) && (cnt != '0)
         && (cnt <= OUT_C);
    byt_w = '0;
    if (val_w)
      byt_w = lst_w ? BYT_WD'(cnt >> 3) : FULL_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      fin_q <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      fin_q <= fin_n;
    end
  end

  assign bus.rdy_o = rdy_w;
  assign bus.val_o = val_w;
  assign bus.dat_o = acc[OUT_WD-1:0];
  assign bus.byt_o = byt_w;
  assign bus.lst_o = lst_w;
endmodule

// File: tb/tb_huffman_fixed_pack.sv
// Self-checking bench for huffman_fixed_pack.
// Reference: RFC1951 base/extra tables into a bit queue.
module tb_huffman_fixed_pack;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  huffman_fixed_pack_if #(.OUT_WD(W)) bus ();

  huffman_fixed_pack #(.OUT_WD(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;

  bit           exp_q[$];
  logic [W-1:0] got_dat[$];
  int           got_byt[$];
  bit           got_lst[$];
  bit           seen_lst = 1'b0;

  logic [W-1:0] first_dat;
  int           first_byt;
  bit           first_lst;

  int lbase[29] = '{3,4,5,6,7,8,9,10,11,13,15,17,
    19,23,27,31,35,43,51,59,67,83,99,115,131,163,
    195,227,258};
  int lxb[29] = '{0,0,0,0,0,0,0,0,1,1,1,1,2,2,2,2,
    3,3,3,3,4,4,4,4,5,5,5,5,0};
  int dbase[30] = '{1,2,3,4,5,7,9,13,17,25,33,49,
    65,97,129,193,257,385,513,769,1025,1537,2049,
    3073,4097,6145,8193,12289,16385,24577};
  int dxb[30] = '{0,0,0,0,1,1,2,2,3,3,4,4,5,5,6,6,
    7,7,8,8,9,9,10,10,11,11,12,12,13,13};

  function automatic void put_lsb(int v, int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(bit'((v >> i) & 1));
  endfunction

  function automatic void put_msb(int v, int n);
    for (int i = n - 1; i >= 0; i--)
      exp_q.push_back(bit'((v >> i) & 1));
  endfunction

  function automatic void put_huff(int sym);
    if (sym < 144)      put_msb(48 + sym, 8);
    else if (sym < 256) put_msb(400 + sym - 144, 9);
    else if (sym < 280) put_msb(sym - 256, 7);
    else                put_msb(192 + sym - 280, 8);
  endfunction

  function automatic void put_tok(
    bit flg, int lit, int len, int dis
  );
    int i;
    int j;
    if (flg) begin
      put_huff(lit);
    end else begin
      i = 28;
      while (lbase[i] > len) i--;
      put_huff(257 + i);
      put_lsb(len - lbase[i], lxb[i]);
      j = 29;
      while (dbase[j] > dis) j--;
      put_msb(j, 5);
      put_lsb(dis - dbase[j], dxb[j]);
    end
  endfunction

  function automatic void start_block(bit fin);
    put_lsb(int'(fin), 1);
    put_lsb(1, 2);
  endfunction

  // downstream ready pattern
  initial begin
    bus.rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.rdy_i = 1'b1;
        1: bus.rdy_i = ~bus.rdy_i;
        default: bus.rdy_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // output monitor: capture, stall hold, backpressure
  initial begin
    bit           stall_p;
    logic [W-1:0] pd;
    int           pb;
    bit           pl;
    stall_p = 1'b0;
    pd = '0;
    pb = 0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p) begin
          n_chk++;
          assert (bus.dat_o === pd
            && int'(bus.byt_o) === pb
            && bus.lst_o === pl)
          else begin
            n_fail++;
            $error("FAIL hold dat=%h/%h byt=%0d/%0d",
              bus.dat_o, pd, bus.byt_o, pb);
          end
        end
        if (bus.val_o && !bus.rdy_i) begin
          n_chk++;
          assert (bus.rdy_o === 1'b0)
          else begin
            n_fail++;
            $error("FAIL backpressure rdy_o=%b want=0",
              bus.rdy_o);
          end
        end
        if (bus.val_o && bus.rdy_i) begin
          got_dat.push_back(bus.dat_o);
          got_byt.push_back(int'(bus.byt_o));
          got_lst.push_back(bus.lst_o);
          if (bus.lst_o) seen_lst = 1'b1;
        end
        stall_p = bus.val_o && !bus.rdy_i;
        pd = bus.dat_o;
        pb = int'(bus.byt_o);
        pl = bus.lst_o;
      end
    end
  end

  task automatic send(
    bit flg, int lit, int len, int dis,
    bit eob, bit fin
  );
    int t;
    bit took;
    bus.val_i     = 1'b1;
    bus.flg_lit_i = flg;
    bus.lit_dat_i = 8'(lit);
    bus.len_dat_i = 9'(len);
    bus.dis_dat_i = 16'(dis);
    bus.eob_i     = eob;
    bus.fin_i     = fin;
    took = 1'b0;
    t = 0;
    while (!took && t < 200) begin
      @(negedge clk);
      took = bus.rdy_o;
      @(posedge clk);
      #1;
      t++;
    end
    bus.val_i = 1'b0;
    n_chk++;
    assert (took === 1'b1)
    else begin
      n_fail++;
      $error("FAIL accept_timeout got=%b want=1", took);
    end
    put_tok(flg, lit, len, dis);
    if (eob) begin
      put_lsb(0, 7);
      if (fin)
        while (exp_q.size() % 8 != 0)
          exp_q.push_back(1'b0);
    end
  endtask

  task automatic rnd_block(int n, bit fin);
    int len;
    int dis;
    start_block(fin);
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 7))
        0: len = 3;
        1: len = 258;
        2: len = 257;
        3: len = 11;
        default: len = int'($urandom_range(3, 258));
      endcase
      case ($urandom_range(0, 7))
        0: dis = 1;
        1: dis = 32768;
        2: dis = 24577;
        3: dis = 5;
        default: dis = int'($urandom_range(1, 32768));
      endcase
      send(1'($urandom_range(0, 1)),
        int'($urandom_range(0, 255)), len, dis,
        k == n - 1, fin);
    end
  endtask

  task automatic finish_stream(string tag);
    int t;
    int nw;
    int nb;
    int idx;
    logic [W-1:0] ew;
    int eb;
    bit el;
    t = 0;
    while (!seen_lst && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_chk++;
    assert (seen_lst === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s lst_timeout got=%b want=1",
        tag, seen_lst);
    end
    nb = exp_q.size();
    nw = (nb + W - 1) / W;
    n_chk++;
    assert (got_dat.size() === nw)
    else begin
      n_fail++;
      $error("FAIL %s words got=%0d want=%0d",
        tag, got_dat.size(), nw);
    end
    for (int i = 0; i < nw && i < got_dat.size(); i++) begin
      ew = '0;
      for (int b = 0; b < W; b++) begin
        idx = i * W + b;
        if (idx < nb) ew[b] = exp_q[idx];
      end
      el = (i == nw - 1);
      eb = el ? (nb - i * W + 7) / 8 : W / 8;
      n_chk++;
      assert (got_dat[i] === ew
        && got_byt[i] === eb
        && got_lst[i] === el)
      else begin
        n_fail++;
        $error("FAIL %s w%0d dat=%h/%h byt=%0d/%0d lst=%b/%b",
          tag, i, got_dat[i], ew, got_byt[i], eb,
          got_lst[i], el);
      end
    end
    first_dat = 'x;
    first_byt = -1;
    first_lst = 1'b0;
    if (got_dat.size() > 0) begin
      first_dat = got_dat[0];
      first_byt = got_byt[0];
      first_lst = got_lst[0];
    end
    exp_q.delete();
    got_dat.delete();
    got_byt.delete();
    got_lst.delete();
    seen_lst = 1'b0;
  endtask

  task automatic chk_word(
    string tag, logic [W-1:0] d, int b, bit l
  );
    n_chk++;
    assert (first_dat === d && first_byt === b
      && first_lst === l)
    else begin
      n_fail++;
      $error("FAIL %s dat=%h/%h byt=%0d/%0d lst=%b/%b",
        tag, first_dat, d, first_byt, b, first_lst, l);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.val_i = 1'b0;
    bus.flg_lit_i = 1'b0;
    bus.lit_dat_i = '0;
    bus.len_dat_i = 9'd3;
    bus.dis_dat_i = 16'd1;
    bus.eob_i = 1'b0;
    bus.fin_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    assert (bus.val_o === 1'b0 && bus.rdy_o === 1'b0
      && bus.lst_o === 1'b0 && bus.byt_o === '0)
    else begin
      n_fail++;
      $error("FAIL reset val=%b rdy=%b lst=%b byt=%0d want=0",
        bus.val_o, bus.rdy_o, bus.lst_o, bus.byt_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // raw deflate of "A"
    start_block(1'b1);
    send(1'b1, 'h41, 3, 1, 1'b1, 1'b1);
    finish_stream("lit_A");
    chk_word("lit_A_word", 32'h0000_0473, 3, 1'b1);

    // shortest pair
    start_block(1'b1);
    send(1'b0, 0, 3, 1, 1'b1, 1'b1);
    finish_stream("pair_3_1");
    chk_word("pair_3_1_word", 32'h0000_0203, 3, 1'b1);

    // longest pair, farthest distance
    start_block(1'b1);
    send(1'b0, 0, 258, 32768, 1'b1, 1'b1);
    finish_stream("pair_258");
    chk_word("pair_258_word", 32'h1FFF_BD1B, 4, 1'b0);

    // 9-bit literals under toggling backpressure
    rdy_mode = 1;
    start_block(1'b1);
    for (int k = 0; k < 100; k++)
      send(1'b1, 'h90, 3, 1, k == 99, 1'b1);
    finish_stream("lit90_toggle");

    // two blocks, second header unaligned
    rdy_mode = 2;
    rnd_block(5, 1'b0);
    rnd_block(5, 1'b1);
    finish_stream("two_blocks");

    for (int s = 0; s < 6; s++) begin
      int nb;
      rdy_mode = s % 3;
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++)
        rnd_block(int'($urandom_range(1, 30)), b == nb - 1);
      finish_stream("random");
    end

    // reset mid-block with 20 bits buffered
    rdy_mode = 0;
    send(1'b1, 'h41, 3, 1, 1'b0, 1'b1);
    send(1'b1, 'h90, 3, 1, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    assert (bus.val_o === 1'b0 && bus.rdy_o === 1'b0)
    else begin
      n_fail++;
      $error("FAIL mid_reset val=%b rdy=%b want=0",
        bus.val_o, bus.rdy_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_dat.delete();
    got_byt.delete();
    got_lst.delete();
    seen_lst = 1'b0;
    start_block(1'b1);
    send(1'b1, 'h41, 3, 1, 1'b1, 1'b1);
    finish_stream("after_reset");
    chk_word("after_reset_word", 32'h0000_0473, 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end
endmodule
